// File: rtl/rtio_timebase.sv
// rtio_timebase: free-running timestamp with start/stop/clear, offset preload and NUM_CH one-shot alarms.
// All outputs registered (fire one cycle after match), no backpressure; define TIMEBASE_LATE_FIRE_EN for >= match with late flag.
module rtio_timebase #(
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_CH        = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            clear,
    input  logic                            offset_en,
    input  logic [COUNTER_WIDTH-1:0]        counter_offset,
    input  logic [NUM_CH*COUNTER_WIDTH-1:0] alarm_time,
    input  logic [NUM_CH-1:0]               alarm_arm,
    input  logic [NUM_CH-1:0]               alarm_disarm,
    output logic [COUNTER_WIDTH-1:0]        counter,
    output logic                            running,
    output logic                            wrap,
    output logic [NUM_CH-1:0]               alarm_pending,
    output logic [NUM_CH-1:0]               alarm_fire,
    output logic [NUM_CH-1:0]               alarm_late
);

    localparam logic [0:0] ST_STOPPED = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic                     wrap_q, wrap_d;
    logic [NUM_CH-1:0]        pending_q, pending_d;
    logic [NUM_CH-1:0]        fire_q, fire_d;
    logic [NUM_CH-1:0]        late_d;
    logic [NUM_CH-1:0]        hit;
    logic [COUNTER_WIDTH-1:0] target_q [NUM_CH];
    logic [COUNTER_WIDTH-1:0] target_d [NUM_CH];

    always_comb begin
        state_d = state_q;
        if (clear || stop) begin
            state_d = ST_STOPPED;
        end else if (start) begin
            state_d = ST_RUNNING;
        end
    end

    // A stop sampled on the same edge suppresses that edge's increment.
    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        if (clear) begin
            counter_d = '0;
        end else if (offset_en) begin
            counter_d = counter_offset;
        end else if (state_q == ST_RUNNING && !stop) begin
            counter_d = counter_q + CNT_ONE;
            wrap_d    = &counter_q;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef TIMEBASE_LATE_FIRE_EN
            hit[i] = (counter_q >= target_q[i]);
`else
            hit[i] = (counter_q == target_q[i]);
`endif
        end
    end

    // Per channel: clear > arm > disarm > match; arm on a matching edge re-targets without firing.
    always_comb begin
        pending_d = pending_q;
        fire_d    = '0;
        late_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            target_d[i] = target_q[i];
            if (clear) begin
                pending_d[i] = 1'b0;
                target_d[i]  = '0;
            end else if (alarm_arm[i]) begin
                pending_d[i] = 1'b1;
                target_d[i]  = alarm_time[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end else if (alarm_disarm[i]) begin
                pending_d[i] = 1'b0;
            end else if (state_q == ST_RUNNING && pending_q[i] && hit[i]) begin
                pending_d[i] = 1'b0;
                fire_d[i]    = 1'b1;
                late_d[i]    = (counter_q != target_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STOPPED;
            counter_q <= '0;
            wrap_q    <= 1'b0;
            pending_q <= '0;
            fire_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
            pending_q <= pending_d;
            fire_q    <= fire_d;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
            end
        end
    end

`ifdef TIMEBASE_LATE_FIRE_EN
    logic [NUM_CH-1:0] late_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            late_q <= '0;
        end else begin
            late_q <= late_d;
        end
    end

    assign alarm_late = late_q;
`else
    // Equality matching can never overshoot, so the late flag is constant.
    logic unused_late;
    assign unused_late = ^late_d;
    assign alarm_late  = '0;
`endif

    assign counter       = counter_q;
    assign running       = (state_q == ST_RUNNING);
    assign wrap          = wrap_q;
    assign alarm_pending = pending_q;
    assign alarm_fire    = fire_q;

endmodule

// File: tb/tb_rtio_timebase.sv
// Self-checking bench for rtio_timebase: direct state checks plus a scoreboard of expected alarm fires.
module tb_rtio_timebase;

    localparam int W  = 64;
    localparam int NC = 4;

    typedef struct {
        int          ch;
        logic [63:0] cnt;
        logic        late;
    } fire_ev_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            clear = 1'b0;
    logic            offset_en = 1'b0;
    logic [W-1:0]    counter_offset = '0;
    logic [NC*W-1:0] alarm_time = '0;
    logic [NC-1:0]   alarm_arm = '0;
    logic [NC-1:0]   alarm_disarm = '0;
    logic [W-1:0]    counter;
    logic            running;
    logic            wrap;
    logic [NC-1:0]   alarm_pending;
    logic [NC-1:0]   alarm_fire;
    logic [NC-1:0]   alarm_late;

    int       n_cmp = 0;
    int       n_err = 0;
    fire_ev_t exp_q[$];

    rtio_timebase #(.COUNTER_WIDTH(W), .NUM_CH(NC)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .clear          (clear),
        .offset_en      (offset_en),
        .counter_offset (counter_offset),
        .alarm_time     (alarm_time),
        .alarm_arm      (alarm_arm),
        .alarm_disarm   (alarm_disarm),
        .counter        (counter),
        .running        (running),
        .wrap           (wrap),
        .alarm_pending  (alarm_pending),
        .alarm_fire     (alarm_fire),
        .alarm_late     (alarm_late)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_to(input logic [63:0] v);
        int n = 0;
        while (counter !== v && n < 2000) begin
            step(1);
            n++;
        end
        if (counter !== v) chk("run_to_timeout", counter, v);
    endtask

    task automatic push_ev(input int ch, input logic [63:0] cnt, input logic late);
        fire_ev_t e;
        e.ch   = ch;
        e.cnt  = cnt;
        e.late = late;
        exp_q.push_back(e);
    endtask

    task automatic set_t(input int ch, input logic [63:0] t);
        alarm_time[ch*W +: W] = t;
    endtask

    // Leaves the counter at 0 in RUNNING with no alarms pending.
    task automatic restart();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Every fire pulse must match the oldest queued expectation, in channel order within a cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (alarm_fire[i]) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_fire", {63'd0, alarm_fire[i]}, 64'd0);
                end else begin
                    fire_ev_t e;
                    e = exp_q.pop_front();
                    chk("fire_ch", i, e.ch);
                    chk("fire_cnt", counter, e.cnt);
                    chk("fire_late", {63'd0, alarm_late[i]}, {63'd0, e.late});
                    chk("fire_pend_clr", {63'd0, alarm_pending[i]}, 64'd0);
                end
            end else if (alarm_late[i]) begin
                chk("late_no_fire", {63'd0, alarm_late[i]}, 64'd0);
            end
        end
    end

    initial begin
        // Reset values
        step(2);
        chk("rst_counter", counter, 64'd0);
        chk("rst_running", {63'd0, running}, 64'd0);
        chk("rst_wrap", {63'd0, wrap}, 64'd0);
        chk("rst_pending", {60'd0, alarm_pending}, 64'd0);
        chk("rst_fire", {60'd0, alarm_fire}, 64'd0);
        chk("rst_late", {60'd0, alarm_late}, 64'd0);
        reset = 1'b0;
        step(1);

        // Start / run / stop / hold
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_running", {63'd0, running}, 64'd1);
        chk("start_counter", counter, 64'd0);
        step(9);
        chk("run9_counter", counter, 64'd9);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_counter", counter, 64'd9);
        chk("stop_running", {63'd0, running}, 64'd0);
        step(5);
        chk("hold_counter", counter, 64'd9);

        // Offset preload near wrap
        restart();
        counter_offset = 64'hFFFF_FFFF_FFFF_FFFE;
        offset_en = 1'b1;
        step(1);
        offset_en = 1'b0;
        chk("ofs_counter", counter, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("ofs_wrap", {63'd0, wrap}, 64'd0);
        step(1);
        chk("ff_counter", counter, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ff_wrap", {63'd0, wrap}, 64'd0);
        step(1);
        chk("wrap_counter", counter, 64'd0);
        chk("wrap_pulse", {63'd0, wrap}, 64'd1);
        step(1);
        chk("post_wrap_counter", counter, 64'd1);
        chk("post_wrap_pulse", {63'd0, wrap}, 64'd0);

        // Multiple channels, simultaneous fire
        restart();
        set_t(0, 64'd20);
        set_t(3, 64'd20);
        set_t(1, 64'd25);
        alarm_arm = 4'b1011;
        step(1);
        alarm_arm = '0;
        chk("arm_pending", {60'd0, alarm_pending}, 64'hB);
        push_ev(0, 64'd21, 1'b0);
        push_ev(3, 64'd21, 1'b0);
        push_ev(1, 64'd26, 1'b0);
        run_to(64'd22);
        chk("after20_pending", {60'd0, alarm_pending}, 64'h2);
        run_to(64'd30);
        chk("after25_pending", {60'd0, alarm_pending}, 64'h0);

        // Disarm, re-arm, arm coinciding with match
        restart();
        set_t(2, 64'd30);
        alarm_arm = 4'b0100;
        step(1);
        alarm_arm = '0;
        run_to(64'd15);
        alarm_disarm = 4'b0100;
        step(1);
        alarm_disarm = '0;
        chk("disarm_pending", {60'd0, alarm_pending}, 64'h0);
        run_to(64'd35);
        set_t(2, 64'd40);
        alarm_arm = 4'b0100;
        step(1);
        alarm_arm = '0;
        push_ev(2, 64'd41, 1'b0);
        run_to(64'd45);
        set_t(1, 64'd60);
        alarm_arm = 4'b0010;
        step(1);
        alarm_arm = '0;
        run_to(64'd60);
        set_t(1, 64'd70);
        alarm_arm = 4'b0010;
        step(1);
        alarm_arm = '0;
        chk("rearm_on_match_pending", {60'd0, alarm_pending}, 64'h2);
        push_ev(1, 64'd71, 1'b0);
        run_to(64'd75);
        chk("rearm_done_pending", {60'd0, alarm_pending}, 64'h0);

        // Target already passed
        restart();
        counter_offset = 64'd100;
        offset_en = 1'b1;
        step(1);
        offset_en = 1'b0;
        set_t(0, 64'd50);
        alarm_arm = 4'b0001;
        step(1);
        alarm_arm = '0;
`ifdef TIMEBASE_LATE_FIRE_EN
        push_ev(0, 64'd102, 1'b1);
        step(5);
        chk("late_pending", {60'd0, alarm_pending}, 64'h0);
`else
        step(5);
        chk("late_pending", {60'd0, alarm_pending}, 64'h1);
`endif

        // Asynchronous reset while running with alarms pending
        restart();
        for (int i = 0; i < NC; i++) set_t(i, 64'd500);
        alarm_arm = 4'b1111;
        step(1);
        alarm_arm = '0;
        step(3);
        chk("pre_rst_pending", {60'd0, alarm_pending}, 64'hF);
        #2 reset = 1'b1;
        #1;
        chk("arst_counter", counter, 64'd0);
        chk("arst_running", {63'd0, running}, 64'd0);
        chk("arst_pending", {60'd0, alarm_pending}, 64'd0);
        chk("arst_wrap", {63'd0, wrap}, 64'd0);
        chk("arst_fire", {60'd0, alarm_fire}, 64'd0);
        step(2);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("rel_counter", counter, 64'd0);
            chk("rel_running", {63'd0, running}, 64'd0);
            chk("rel_wrap", {63'd0, wrap}, 64'd0);
        end

        // Synchronous clear while running with an alarm pending
        start = 1'b1;
        step(1);
        start = 1'b0;
        set_t(0, 64'd500);
        alarm_arm = 4'b0001;
        step(1);
        alarm_arm = '0;
        step(3);
        chk("pre_clr_counter", counter, 64'd4);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_counter", counter, 64'd0);
        chk("clr_running", {63'd0, running}, 64'd0);
        chk("clr_pending", {60'd0, alarm_pending}, 64'd0);
        chk("clr_wrap", {63'd0, wrap}, 64'd0);
        step(3);
        chk("clr_hold_counter", counter, 64'd0);

        chk("queue_drained", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
